// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache block-fill controller.
package cache_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   localparam int BLOCK_WORDS    = 8;
   localparam int WORD_IDX_W     = 3;
   localparam int BLOCK_OFFSET_W = 4;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Miss/memory/array handshake bundle between a cache and its fill controller.
interface cache_fill_fsm_if
   import cache_pkg::*;
#(
   parameter int ADDR_W = 16
) ();

   logic                  miss_detected;
   logic [ADDR_W-1:0]     miss_address;
   logic                  memory_data_valid;
   logic [15:0]           memory_data;
   logic                  fsm_busy;
   logic                  memory_read;
   logic [ADDR_W-1:0]     memory_address;
   logic                  write_data_array;
   logic [WORD_IDX_W-1:0] data_word_index;
   logic [15:0]           data_word;
   logic                  write_tag_array;

   // master: the fill controller; slave: the cache plus main memory around it
   modport master (
      input  miss_detected, miss_address, memory_data_valid, memory_data,
      output fsm_busy, memory_read, memory_address, write_data_array,
             data_word_index, data_word, write_tag_array
   );

   modport slave (
      output miss_detected, miss_address, memory_data_valid, memory_data,
      input  fsm_busy, memory_read, memory_address, write_data_array,
             data_word_index, data_word, write_tag_array
   );

endinterface

// File: rtl/fill_word_counter.sv
// Loadable word-index counter that wraps modulo the block size and flags
// when a full block's worth of increments has been taken.
module fill_word_counter
   import cache_pkg::*;
#(
   parameter int W = WORD_IDX_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         inc_i,
   output logic [W-1:0] idx_o,
   output logic         last_o,
   output logic         done_o
);

   localparam logic [W:0] LAST_CNT = (W+1)'(BLOCK_WORDS - 1);
   localparam logic [W:0] DONE_CNT = (W+1)'(BLOCK_WORDS);

   logic [W-1:0] idx_q, idx_d;
   logic [W:0]   cnt_q, cnt_d;

   assign idx_o  = idx_q;
   assign last_o = (cnt_q == LAST_CNT);
   assign done_o = (cnt_q == DONE_CNT);

   // idx wraps freely; cnt saturates at a full block so extra incs are inert
   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      if (load_i) begin
         idx_d = load_val_i;
         cnt_d = '0;
      end else if (inc_i && !done_o) begin
         idx_d = idx_q + 1'b1;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         cnt_q <= '0;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: requests one block from memory, streams words
// into the data array, then writes the tag. Option: CACHE_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   cache_fill_fsm_if.master bus
);

   localparam int BLK_W = ADDR_W - BLOCK_OFFSET_W;

   fill_state_e           state_q, state_d;
   logic [BLK_W-1:0]      blk_q, blk_d;
   logic [WORD_IDX_W-1:0] start_idx;
   logic [WORD_IDX_W-1:0] req_idx, rcv_idx;
   logic                  ctr_load, req_inc, rcv_inc;
   logic                  req_done, rcv_last, rcv_done;
   logic                  unused_req_last;
   logic                  unused_addr_bits;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   assign start_idx        = bus.miss_address[BLOCK_OFFSET_W-1:1];
   assign unused_addr_bits = bus.miss_address[0];
`else
   assign start_idx        = '0;
   assign unused_addr_bits = ^bus.miss_address[BLOCK_OFFSET_W-1:0];
`endif

   fill_word_counter #(.W(WORD_IDX_W)) u_req_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ctr_load),
      .load_val_i (start_idx),
      .inc_i      (req_inc),
      .idx_o      (req_idx),
      .last_o     (unused_req_last),
      .done_o     (req_done)
   );

   fill_word_counter #(.W(WORD_IDX_W)) u_rcv_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ctr_load),
      .load_val_i (start_idx),
      .inc_i      (rcv_inc),
      .idx_o      (rcv_idx),
      .last_o     (rcv_last),
      .done_o     (rcv_done)
   );

   always_comb begin
      state_d              = state_q;
      blk_d                = blk_q;
      ctr_load             = 1'b0;
      req_inc              = 1'b0;
      rcv_inc              = 1'b0;
      bus.fsm_busy         = 1'b0;
      bus.memory_read      = 1'b0;
      bus.memory_address   = '0;
      bus.write_data_array = 1'b0;
      bus.data_word_index  = '0;
      bus.data_word        = '0;
      bus.write_tag_array  = 1'b0;
      case (state_q)
         IDLE: begin
            // stall in the miss cycle itself; stray memory valids are ignored here
            bus.fsm_busy = bus.miss_detected;
            if (bus.miss_detected) begin
               blk_d    = bus.miss_address[ADDR_W-1:BLOCK_OFFSET_W];
               ctr_load = 1'b1;
               state_d  = FILL;
            end
         end
         FILL: begin
            bus.fsm_busy = 1'b1;
            if (!req_done) begin
               bus.memory_read    = 1'b1;
               bus.memory_address = {blk_q, req_idx, 1'b0};
               req_inc            = 1'b1;
            end
            if (bus.memory_data_valid && !rcv_done) begin
               bus.write_data_array = 1'b1;
               bus.data_word_index  = rcv_idx;
               bus.data_word        = bus.memory_data;
               rcv_inc              = 1'b1;
               if (rcv_last) begin
                  bus.write_tag_array = 1'b1;
                  state_d             = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency in-order memory model.
module tb_cache_fill_fsm;
   import cache_pkg::*;

   localparam int MEM_LATENCY = 4;

   typedef struct {
      logic [15:0] miss_addr;
      logic [15:0] exp_base;
      bit          hold;
      int          rst_after;
      int          exp_busy;
      int          exp_wr;
      int          exp_tag;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   cache_fill_fsm_if #(.ADDR_W(16)) bus ();

   cache_fill_fsm #(.ADDR_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic        pipe_v [MEM_LATENCY];
   logic [15:0] pipe_a [MEM_LATENCY];
   logic        s_busy, s_rd, s_wr, s_tag, s_mv;
   logic [15:0] s_addr, s_data;
   logic [2:0]  s_idx;
   vec_t        vecs [7];

   function automatic logic [15:0] mdata(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // sample outputs mid-cycle, then advance memory model one clock
   task automatic cycle();
      @(negedge clk);
      s_busy = bus.fsm_busy;
      s_rd   = bus.memory_read;
      s_addr = bus.memory_address;
      s_wr   = bus.write_data_array;
      s_idx  = bus.data_word_index;
      s_data = bus.data_word;
      s_tag  = bus.write_tag_array;
      s_mv   = bus.memory_data_valid;
      @(posedge clk);
      for (int i = MEM_LATENCY-1; i > 0; i--) begin
         pipe_v[i] = pipe_v[i-1];
         pipe_a[i] = pipe_a[i-1];
      end
      pipe_v[0] = s_rd;
      pipe_a[0] = s_addr;
      #1;
      bus.memory_data_valid = pipe_v[MEM_LATENCY-1];
      bus.memory_data       = pipe_v[MEM_LATENCY-1] ? mdata(pipe_a[MEM_LATENCY-1]) : 16'h0000;
   endtask

   task automatic run_fill(input vec_t v);
      int         nrd   = 0;
      int         nwr   = 0;
      int         ntag  = 0;
      int         nbusy = 0;
      int         nlate = 0;
      bit         fin   = 0;
      logic [2:0] start;
      logic [2:0] e_idx;
      logic [15:0] e_addr;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      start = v.miss_addr[3:1];
`else
      start = 3'd0;
`endif
      bus.miss_detected = 1'b1;
      bus.miss_address  = v.miss_addr;
      cycle();
      check("miss_cycle_busy", s_busy, 1);
      check("miss_cycle_no_read", s_rd, 0);
      if (s_busy) nbusy++;
      if (!v.hold) bus.miss_detected = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin
         cycle();
         if (s_busy) nbusy++;
         if (s_rd) begin
            e_idx  = start + 3'(nrd);
            e_addr = v.exp_base | {12'h000, e_idx, 1'b0};
            check("rd_addr", s_addr, e_addr);
            nrd++;
            if (v.hold) bus.miss_address = 16'h7778;
         end
         if (s_wr) begin
            e_idx  = start + 3'(nwr);
            e_addr = v.exp_base | {12'h000, e_idx, 1'b0};
            check("wr_index", s_idx, e_idx);
            check("wr_data", s_data, mdata(e_addr));
            nwr++;
         end
         if (s_tag) begin
            ntag++;
            check("tag_with_8th_write", {s_wr, 4'(nwr)}, {1'b1, 4'd8});
         end
         if (v.rst_after > 0 && nwr == v.rst_after) fin = 1;
         else if (v.hold && s_tag)                  fin = 1;
         else if (!s_busy)                          fin = 1;
      end
      if (!fin) check("fill_timeout", 0, 1);
      check("busy_cycles", nbusy, v.exp_busy);
      check("read_count", nrd, 8);
      check("write_count", nwr, v.exp_wr);
      check("tag_count", ntag, v.exp_tag);
      if (v.hold) bus.miss_address = v.miss_addr;
      if (v.rst_after > 0) begin
         rst_n = 1'b0;
         #1;
         check("rst_busy", bus.fsm_busy, 0);
         check("rst_read", bus.memory_read, 0);
         check("rst_addr", bus.memory_address, 0);
         check("rst_wr", bus.write_data_array, 0);
         check("rst_data", bus.data_word, 0);
         check("rst_tag", bus.write_tag_array, 0);
         #2;
         rst_n = 1'b1;
         for (int c = 0; c < 6; c++) begin
            cycle();
            if (s_mv) nlate++;
            check("late_valid_no_write", {s_wr, s_tag, s_busy}, 3'b000);
         end
         check("late_valid_count", nlate, 3);
      end
   endtask

   initial begin
      vecs[0] = '{16'h1236, 16'h1230, 1'b0, 0, 13, 8, 1};
      vecs[1] = '{16'hABCF, 16'hABC0, 1'b0, 0, 13, 8, 1};
      vecs[2] = '{16'h5552, 16'h5550, 1'b1, 0, 13, 8, 1};
      vecs[3] = '{16'h5552, 16'h5550, 1'b0, 0, 13, 8, 1};
      vecs[4] = '{16'hFFF0, 16'hFFF0, 1'b0, 0, 13, 8, 1};
      vecs[5] = '{16'h0000, 16'h0000, 1'b0, 0, 13, 8, 1};
      vecs[6] = '{16'h2468, 16'h2460, 1'b0, 5, 10, 5, 0};
      for (int i = 0; i < MEM_LATENCY; i++) begin
         pipe_v[i] = 1'b0;
         pipe_a[i] = 16'h0000;
      end
      bus.miss_detected     = 1'b0;
      bus.miss_address      = 16'h0000;
      bus.memory_data_valid = 1'b0;
      bus.memory_data       = 16'h0000;
      #12;
      check("reset_busy", bus.fsm_busy, 0);
      check("reset_read", bus.memory_read, 0);
      check("reset_addr", bus.memory_address, 0);
      check("reset_wr", bus.write_data_array, 0);
      check("reset_idx", bus.data_word_index, 0);
      check("reset_data", bus.data_word, 0);
      check("reset_tag", bus.write_tag_array, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_fill(vecs[i]);

      // stray memory response while idle
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'hBEEF;
      cycle();
      check("stray_no_write", s_wr, 0);
      check("stray_busy", s_busy, 0);
      check("stray_data", s_data, 0);
      check("stray_tag", s_tag, 0);

      run_fill('{16'h9ABE, 16'h9AB0, 1'b0, 0, 13, 8, 1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
